// File: rtl/uart_rx.sv
// 8N1 UART receiver: samples the line at mid-bit using a prescale*8 bit period
// and delivers each received word on an AXI4-Stream master port.
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] output_axis_tdata,
    output logic                  output_axis_tvalid,
    input  logic                  output_axis_tready,
    input  logic                  rxd,
    output logic                  busy,
    output logic                  overrun_error,
    output logic                  frame_error,
    input  logic [15:0]           prescale
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 3);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(DATA_WIDTH + 2);
    localparam logic [CNT_W-1:0] STOP_CNT  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECV     = 2'd1,
        ERR_WAIT = 2'd2
    } state_t;

    state_t                state_q;
    logic                  rxd_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [18:0]           presc_cnt_q;
    logic [15:0]           presc_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  busy_q;
    logic                  overrun_q;
    logic                  frame_err_q;

    // Half a bit period: lands the start-bit check in the middle of the start bit.
    function automatic logic [18:0] half_bit(input logic [15:0] p);
        return {1'b0, p, 2'b00} - 19'd1;
    endfunction

    function automatic logic [18:0] full_bit(input logic [15:0] p);
        return {p, 3'b000} - 19'd1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] s,
                                                       input logic b);
        logic [DATA_WIDTH-1:0] r;
        r = s >> 1;
        r[DATA_WIDTH-1] = b;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rxd_q       <= 1'b1;
            bit_cnt_q   <= '0;
            presc_cnt_q <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rxd_q       <= rxd;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;

            if (tvalid_q && output_axis_tready) begin
                tvalid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rxd_q) begin
                        presc_q     <= prescale;
                        presc_cnt_q <= half_bit(prescale);
                        bit_cnt_q   <= START_CNT;
                        busy_q      <= 1'b1;
                        state_q     <= RECV;
                    end
                end

                RECV: begin
                    if (presc_cnt_q != 19'd0) begin
                        presc_cnt_q <= presc_cnt_q - 19'd1;
                    end else if (bit_cnt_q == START_CNT) begin
                        if (rxd_q) begin
                            // Glitch shorter than half a bit: not a real start.
                            bit_cnt_q <= '0;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            presc_cnt_q <= full_bit(presc_q);
                            bit_cnt_q   <= bit_cnt_q - CNT_W'(1);
                        end
                    end else if (bit_cnt_q == STOP_CNT) begin
                        bit_cnt_q <= '0;
                        if (rxd_q) begin
                            tdata_q   <= shift_q;
                            tvalid_q  <= 1'b1;
                            overrun_q <= tvalid_q && !output_axis_tready;
                            busy_q    <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ERR_WAIT;
                        end
                    end else begin
                        shift_q     <= shift_in(shift_q, rxd_q);
                        presc_cnt_q <= full_bit(presc_q);
                        bit_cnt_q   <= bit_cnt_q - CNT_W'(1);
                    end
                end

                ERR_WAIT: begin
                    // A held-low (break) line must not re-trigger reception.
                    if (rxd_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end

                default: begin
                    bit_cnt_q <= '0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign busy               = busy_q;
    assign overrun_error      = overrun_q;
    assign frame_error        = frame_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames and checks delivered words, timing,
// busy span and error pulses against arithmetic derived from the bit timing.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready = 1'b1;
    logic        rxd = 1'b1;
    logic        busy;
    logic        ovr;
    logic        ferr;
    logic [15:0] prescale = 16'd1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    uart_rx #(.DATA_WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .output_axis_tdata (tdata),
        .output_axis_tvalid(tvalid),
        .output_axis_tready(tready),
        .rxd               (rxd),
        .busy              (busy),
        .overrun_error     (ovr),
        .frame_error       (ferr),
        .prescale          (prescale)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Event log built from stream semantics: a new word is on the bus when
    // tvalid is high and the previous cycle had no valid, a handshake, or other data.
    int   load_cyc[$];
    int   load_dat[$];
    int   acc_dat[$];
    int   ovr_cyc[$];
    int   ferr_cyc[$];
    int   busy_cnt = 0;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [7:0] pd = 8'd0;

    always @(negedge clk) begin
        if (tvalid && (!pv || pr || tdata != pd)) begin
            load_cyc.push_back(cyc);
            load_dat.push_back(int'(tdata));
        end
        if (tvalid && tready) acc_dat.push_back(int'(tdata));
        if (ovr) ovr_cyc.push_back(cyc);
        if (ferr) ferr_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        pv = tvalid;
        pr = tready;
        pd = tdata;
    end

    task automatic clear_logs();
        load_cyc.delete();
        load_dat.delete();
        acc_dat.delete();
        ovr_cyc.delete();
        ferr_cyc.delete();
        busy_cnt = 0;
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at #1 after a posedge; start bit begins in the current cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int p);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rxd = bits[k];
            repeat (8 * p) @(posedge clk);
            #1;
        end
    endtask

    // Line change at c0 -> rxd_q low at c0+1 (start detect), stop sample
    // 4P + 8P*9 later, word visible one cycle after that.
    function automatic int exp_cyc(input int c0, input int p);
        return c0 + 1 + 4 * p + 8 * p * 9 + 1;
    endfunction

    initial begin
        int c0;
        int p;
        logic [7:0] d;
        logic [7:0] w1;
        logic [7:0] w2;

        idle(4);
        chk("rst_tdata", tdata, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_ferr", ferr, 0);
        rst = 1'b0;
        idle(4);

        // Basic frame
        clear_logs();
        c0 = cyc;
        send_frame(8'h55, 1'b1, 1);
        idle(4);
        chk("basic_nload", load_dat.size(), 1);
        chk("basic_data", qget(load_dat, 0), 32'h55);
        chk("basic_cyc", qget(load_cyc, 0), exp_cyc(c0, 1));
        chk("basic_nacc", acc_dat.size(), 1);
        chk("basic_busy", busy_cnt, 76);
        chk("basic_ovr", ovr_cyc.size(), 0);
        chk("basic_ferr", ferr_cyc.size(), 0);
        chk("basic_tvalid_after", tvalid, 0);

        // Random words at random prescale
        for (int i = 0; i < 4; i++) begin
            p = int'($urandom_range(1, 3));
            d = 8'($urandom_range(0, 255));
            prescale = 16'(p);
            clear_logs();
            c0 = cyc;
            send_frame(d, 1'b1, p);
            idle(3);
            chk("rand_nload", load_dat.size(), 1);
            chk("rand_data", qget(load_dat, 0), 32'(d));
            chk("rand_cyc", qget(load_cyc, 0), exp_cyc(c0, p));
            chk("rand_busy", busy_cnt, 76 * p);
        end
        prescale = 16'd1;
        idle(4);

        // Backpressure and overrun
        tready = 1'b0;
        clear_logs();
        c0 = cyc;
        send_frame(8'hA3, 1'b1, 1);
        send_frame(8'h3C, 1'b1, 1);
        idle(3);
        chk("ovr_nload", load_dat.size(), 2);
        chk("ovr_first", qget(load_dat, 0), 32'hA3);
        chk("ovr_second", qget(load_dat, 1), 32'h3C);
        chk("ovr_second_cyc", qget(load_cyc, 1), exp_cyc(c0 + 80, 1));
        chk("ovr_npulse", ovr_cyc.size(), 1);
        chk("ovr_pulse_cyc", qget(ovr_cyc, 0), exp_cyc(c0 + 80, 1));
        chk("ovr_held_valid", tvalid, 1);
        chk("ovr_held_data", tdata, 32'h3C);
        tready = 1'b1;
        idle(1);
        tready = 1'b0;
        idle(2);
        chk("ovr_nacc", acc_dat.size(), 1);
        chk("ovr_acc", qget(acc_dat, 0), 32'h3C);
        chk("ovr_drained", tvalid, 0);

        // Handshake in the cycle the second word is loaded
        w1 = 8'($urandom_range(0, 255));
        w2 = 8'($urandom_range(0, 255));
        clear_logs();
        c0 = cyc;
        fork
            begin
                send_frame(w1, 1'b1, 1);
                send_frame(w2, 1'b1, 1);
            end
            begin
                repeat (80 + 77) @(posedge clk);
                #1 tready = 1'b1;
                @(posedge clk);
                #1 tready = 1'b0;
            end
        join
        idle(3);
        chk("sim_nload", load_dat.size(), 2);
        chk("sim_first", qget(load_dat, 0), 32'(w1));
        chk("sim_second", qget(load_dat, 1), 32'(w2));
        chk("sim_novr", ovr_cyc.size(), 0);
        chk("sim_nacc", acc_dat.size(), 1);
        chk("sim_acc", qget(acc_dat, 0), 32'(w1));
        chk("sim_valid", tvalid, 1);
        chk("sim_data", tdata, 32'(w2));
        tready = 1'b1;
        idle(4);

        // Frame error followed by a held-low line
        clear_logs();
        c0 = cyc;
        send_frame(8'hFF, 1'b0, 1);
        idle(40);
        chk("ferr_busy_low_line", busy, 1);
        rxd = 1'b1;
        idle(60);
        chk("ferr_npulse", ferr_cyc.size(), 1);
        chk("ferr_pulse_cyc", qget(ferr_cyc, 0), exp_cyc(c0, 1));
        chk("ferr_nload", load_dat.size(), 0);
        chk("ferr_tvalid", tvalid, 0);
        chk("ferr_novr", ovr_cyc.size(), 0);
        chk("ferr_busy_span", busy_cnt, 80 + 40);

        // False start: 3-cycle glitch at P=2
        prescale = 16'd2;
        clear_logs();
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(6);
        chk("fs_busy_c9", busy, 1);
        idle(1);
        chk("fs_busy_c10", busy, 0);
        idle(20);
        chk("fs_nload", load_dat.size(), 0);
        chk("fs_busy_span", busy_cnt, 8);
        chk("fs_nerr", ovr_cyc.size() + ferr_cyc.size(), 0);
        clear_logs();
        c0 = cyc;
        send_frame(8'h81, 1'b1, 2);
        idle(3);
        chk("fs_next_data", qget(load_dat, 0), 32'h81);
        chk("fs_next_cyc", qget(load_cyc, 0), exp_cyc(c0, 2));
        prescale = 16'd1;
        idle(4);

        // Reset mid data bit drops held word and partial frame
        tready = 1'b0;
        send_frame(8'($urandom_range(0, 255)), 1'b1, 1);
        idle(3);
        chk("rstmid_held", tvalid, 1);
        clear_logs();
        fork
            send_frame(8'($urandom_range(0, 255)), 1'b1, 1);
            begin
                repeat (20) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1;
                chk("rstmid_tvalid", tvalid, 0);
                chk("rstmid_tdata", tdata, 0);
                chk("rstmid_busy", busy, 0);
                chk("rstmid_errs", {ovr, ferr}, 0);
            end
        join
        rxd = 1'b1;
        idle(2);
        rst = 1'b0;
        tready = 1'b1;
        idle(20);
        chk("rstmid_nload", load_dat.size(), 0);

        // Prescale change mid-frame is ignored
        prescale = 16'd3;
        clear_logs();
        c0 = cyc;
        fork
            send_frame(8'h0F, 1'b1, 3);
            begin
                repeat (100) @(posedge clk);
                #1 prescale = 16'd1;
            end
        join
        idle(4);
        chk("presc_nload", load_dat.size(), 1);
        chk("presc_data", qget(load_dat, 0), 32'h0F);
        chk("presc_cyc", qget(load_cyc, 0), exp_cyc(c0, 3));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
